mem_arbiter: RTL and testbench

Parametrised N-channel arbiter and byte-serial sequencer between the pipeline's memory requesters (instruction fetch, load/store, and future prefetch or cache-fill ports) and the 8-bit external memory bus. Each channel issues one word-sized request. The block selects one request, runs it as single-byte bus cycles in little-endian order, handles UART back-pressure and the `rdy_in` pause, and returns a one-cycle completion pulse. It supersedes the fixed two-port memory controller, adding a configurable channel count, data width, arbitration mode and per-channel read abort.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter / byte-serial sequencer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    // Address field that selects the UART window.
    localparam logic [1:0] IO_SEL = 2'b11;
    localparam int IO_MSB = 17;
    localparam int IO_LSB = 16;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational N-way priority picker: scans from i_start upward with wrap,
// returns a one-hot grant, its index and whether anything was requesting.
module rr_picker #(
    parameter int N  = 2,
    parameter int CW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [CW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [CW-1:0] o_idx,
    output logic          o_found
);

    int w_c;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            w_c = int'(i_start) + k;
            if (w_c >= N) w_c = w_c - N;
            if (!o_found && i_req[w_c]) begin
                o_found    = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = CW'(w_c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter that runs one word request at a time as little-endian
// single-byte cycles on the 8-bit memory bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = $clog2(DATA_W/8) + 1,
    parameter int RR_MODE = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*32-1:0]     req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    input  logic [NUM_CH-1:0]        req_flush,
    output logic [NUM_CH-1:0]        rsp_done,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [31:0]              mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int NB = DATA_W / 8;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t r_state, w_next;

    logic [31:0]       r_addr, r_last_a;
    logic [DATA_W-1:0] r_wdata, r_buf;
    logic [LEN_W-1:0]  r_len, r_idx, r_plane;
    logic [CW-1:0]     r_ch, r_ptr;
    logic              r_pend;
    logic [7:0]        r_last_dout;

    logic [NUM_CH-1:0] w_gnt;
    logic [CW-1:0]     w_gidx, w_start;
    logic              w_found, w_grant, w_issue, w_wr_go, w_finish;
    logic [LEN_W-1:0]  w_win_len, w_len_n;
    logic              w_io, w_flush, w_addr_cyc;
    logic [DATA_W-1:0] w_asm, w_wshift;

    // A channel whose completion is showing this cycle must not be re-granted.
    assign w_start = (RR_MODE == ARB_RR) ? r_ptr : '0;

    rr_picker #(.N(NUM_CH), .CW(CW)) u_pick (
        .i_req   (req_valid & ~rsp_done),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_idx   (w_gidx),
        .o_found (w_found)
    );

    assign w_win_len = req_len[w_gidx*LEN_W +: LEN_W];
    assign w_len_n   = (w_win_len == '0 || w_win_len > LEN_W'(NB)) ? LEN_W'(NB) : w_win_len;

    assign w_io       = (r_addr[IO_MSB:IO_LSB] == IO_SEL);
    assign w_flush    = req_flush[r_ch];
    assign w_addr_cyc = (r_state == ST_READ) && (r_idx < r_len);

    // Read byte for the address issued last cycle lands in lane r_plane.
    assign w_asm    = r_pend ? (r_buf | (DATA_W'(mem_din) << {r_plane, 3'b000})) : r_buf;
    assign w_wshift = r_wdata >> {r_idx, 3'b000};

    assign mem_a    = (w_addr_cyc || r_state == ST_WRITE) ? r_addr + 32'(r_idx) : r_last_a;
    assign mem_dout = (r_state == ST_WRITE) ? w_wshift[7:0] : r_last_dout;
    assign mem_wr   = w_wr_go;

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_issue  = 1'b0;
        w_wr_go  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rdy_in && w_found) begin
                    w_grant = 1'b1;
                    w_next  = (|(req_wr & w_gnt)) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (w_flush) begin
                    w_next = ST_IDLE;
                end else if (rdy_in) begin
                    if (w_addr_cyc) begin
                        w_issue = 1'b1;
                    end else begin
                        // Drain cycle: last byte is captured now.
                        w_next   = ST_IDLE;
                        w_finish = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (rdy_in && !(w_io && io_buffer_full)) begin
                    w_wr_go = 1'b1;
                    if (r_idx == r_len - 1'b1) begin
                        w_next   = ST_IDLE;
                        w_finish = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_addr      <= '0;
            r_last_a    <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_plane     <= '0;
            r_ch        <= '0;
            r_ptr       <= '0;
            r_pend      <= 1'b0;
            r_last_dout <= '0;
            rsp_done    <= '0;
            rsp_rdata   <= '0;
        end else begin
            r_last_a    <= mem_a;
            r_last_dout <= mem_dout;
            rsp_done    <= '0;
            r_pend      <= w_issue;
            if (r_pend) r_buf <= w_asm;
            if (w_issue) r_plane <= r_idx;
            if (w_issue || w_wr_go) r_idx <= r_idx + 1'b1;
            if (w_grant) begin
                r_addr  <= req_addr[w_gidx*32 +: 32];
                r_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
                r_len   <= w_len_n;
                r_ch    <= w_gidx;
                r_idx   <= '0;
                r_buf   <= '0;
                if (RR_MODE == ARB_RR)
                    r_ptr <= (w_gidx == CW'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
            end
            if (w_finish) begin
                rsp_done[r_ch] <= 1'b1;
                if (r_state == ST_READ) rsp_rdata <= w_asm;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share a byte memory model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, io_buffer_full = 1'b0;
    logic [1:0]  req_valid = '0, req_wr = '0, req_flush = '0, rr_valid = '0, rr_flush = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [5:0]  req_len = '0;
    logic [1:0]  rsp_done, rr_done;
    logic [31:0] rsp_rdata, rr_rdata, mem_a, rr_a;
    logic [7:0]  mem_din = '0, rr_din = '0, mem_dout, rr_dout;
    logic        mem_wr, rr_wr;

    logic [7:0]  mem [0:1023];
    int          cyc = 0, checks = 0, errors = 0;

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [1:0] ch; logic [31:0] data; bit is_rd; int at; } done_t;
    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [1:0]  rr_exp[$];
    wr_t         mw;
    done_t       md;
    logic [1:0]  mr;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    always @(posedge clk_in) begin
        mem_din <= mem[mem_a[9:0]];
        rr_din  <= mem[rr_a[9:0]];
    end

    mem_arbiter #(.NUM_CH(2), .DATA_W(32), .LEN_W(3), .RR_MODE(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(req_valid),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .req_flush(req_flush), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full));

    mem_arbiter #(.NUM_CH(2), .DATA_W(32), .LEN_W(3), .RR_MODE(1)) dut_rr (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(rr_valid),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .req_flush(rr_flush), .rsp_done(rr_done), .rsp_rdata(rr_rdata), .mem_din(rr_din),
        .mem_dout(rr_dout), .mem_a(rr_a), .mem_wr(rr_wr), .io_buffer_full(io_buffer_full));

    // Output monitor: pops expectations as bus writes and completions appear.
    always @(negedge clk_in) if (rst_in) begin
        if (mem_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++; $display("FAIL bus_write: unexpected write a=%h d=%h at cycle %0d", mem_a, mem_dout, cyc);
            end else begin
                mw = exp_wr.pop_front();
                if (mem_a !== mw.a || mem_dout !== mw.d) begin
                    errors++; $display("FAIL bus_write: got a=%h d=%h, want a=%h d=%h", mem_a, mem_dout, mw.a, mw.d);
                end
            end
        end
        if (rsp_done != 2'b00) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++; $display("FAIL rsp_done: unexpected done=%b at cycle %0d", rsp_done, cyc);
            end else begin
                md = exp_done.pop_front();
                if (rsp_done !== md.ch || cyc != md.at || (md.is_rd && rsp_rdata !== md.data)) begin
                    errors++;
                    $display("FAIL rsp_done: got done=%b cyc=%0d rdata=%h, want done=%b cyc=%0d rdata=%h",
                             rsp_done, cyc, rsp_rdata, md.ch, md.at, md.data);
                end
            end
        end
        if (rr_done != 2'b00) begin
            checks++;
            if (rr_exp.size() == 0) begin
                errors++; $display("FAIL rr_grant: unexpected done=%b", rr_done);
            end else begin
                mr = rr_exp.pop_front();
                if (rr_done !== mr) begin
                    errors++; $display("FAIL rr_grant: got done=%b, want %b", rr_done, mr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] len);
        req_wr[ch]           = wr;
        req_addr[ch*32 +: 32]  = a;
        req_wdata[ch*32 +: 32] = wd;
        req_len[ch*3 +: 3]     = len;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks += 5;
        if (mem_a !== 32'h0)     begin errors++; $display("FAIL reset_mem_a: got %h, want 0", mem_a); end
        if (mem_wr !== 1'b0)     begin errors++; $display("FAIL reset_mem_wr: got %b, want 0", mem_wr); end
        if (mem_dout !== 8'h0)   begin errors++; $display("FAIL reset_mem_dout: got %h, want 0", mem_dout); end
        if (rsp_done !== 2'b00)  begin errors++; $display("FAIL reset_rsp_done: got %b, want 00", rsp_done); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h, want 0", rsp_rdata); end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int n;
        set_ch(1, 1'b0, 32'h100, 32'h0, 3'd4);
        req_valid = 2'b10;
        exp_done.push_back('{2'b10, 32'h44332211, 1'b1, cyc + 6});
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mem_a !== 32'h100 + i || mem_wr !== 1'b0) begin
                errors++; $display("FAIL read_addr[%0d]: got a=%h wr=%b, want a=%h wr=0", i, mem_a, mem_wr, 32'h100 + i);
            end
        end
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0) begin errors++; $display("FAIL read_timeout: %0d done pending, want 0", exp_done.size()); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_io_write();
        int n;
        set_ch(0, 1'b1, 32'h30000, 32'h0000BEEF, 3'd2);
        io_buffer_full = 1'b1;
        req_valid = 2'b01;
        exp_wr.push_back('{32'h30000, 8'hEF});
        exp_wr.push_back('{32'h30001, 8'hBE});
        exp_done.push_back('{2'b01, 32'h0, 1'b0, cyc + 6});
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_hold[%0d]: mem_wr got %b, want 0", i, mem_wr); end
        end
        tick();
        io_buffer_full = 1'b0;
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL io_timeout: pending done=%0d wr=%0d, want 0 0", exp_done.size(), exp_wr.size());
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_fixed_prio();
        int n;
        set_ch(0, 1'b1, 32'h40, 32'h77, 3'd1);
        set_ch(1, 1'b0, 32'h100, 32'h0, 3'd2);
        req_valid = 2'b11;
        exp_wr.push_back('{32'h40, 8'h77});
        exp_done.push_back('{2'b01, 32'h0, 1'b0, cyc + 2});
        exp_done.push_back('{2'b10, 32'h00002211, 1'b1, cyc + 6});
        n = 0;
        while (exp_done.size() > 1 && n < 40) begin tick(); n++; end
        req_valid[0] = 1'b0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0) begin errors++; $display("FAIL prio_timeout: %0d done pending, want 0", exp_done.size()); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_flush();
        int n;
        set_ch(1, 1'b0, 32'h100, 32'h0, 3'd4);
        set_ch(0, 1'b0, 32'h200, 32'h0, 3'd2);
        req_valid = 2'b10;
        exp_done.push_back('{2'b01, 32'h00005CA5, 1'b1, cyc + 8});
        tick();
        req_valid[0] = 1'b1;
        tick(); tick();
        req_flush[1] = 1'b1;
        req_valid[1] = 1'b0;
        tick();
        req_flush[1] = 1'b0;
        checks++;
        if (mem_a !== 32'h102 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got a=%h wr=%b, want a=00000102 wr=0", mem_a, mem_wr);
        end
        tick();
        checks++;
        if (mem_a !== 32'h200) begin errors++; $display("FAIL flush_next_grant: mem_a got %h, want 00000200", mem_a); end
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0) begin errors++; $display("FAIL flush_timeout: %0d done pending, want 0", exp_done.size()); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_rdy_stall();
        int n;
        set_ch(1, 1'b1, 32'h500, 32'hDDCCBBAA, 3'd4);
        req_valid = 2'b10;
        exp_wr.push_back('{32'h500, 8'hAA});
        exp_wr.push_back('{32'h501, 8'hBB});
        exp_wr.push_back('{32'h502, 8'hCC});
        exp_wr.push_back('{32'h503, 8'hDD});
        exp_done.push_back('{2'b10, 32'h0, 1'b0, cyc + 7});
        tick();
        checks++;
        if (mem_wr !== 1'b1) begin errors++; $display("FAIL stall_first: mem_wr got %b, want 1", mem_wr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            rdy_in = 1'b0;
            #1;
            checks++;
            if (mem_wr !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: mem_wr got %b, want 0", i, mem_wr); end
        end
        tick();
        rdy_in = 1'b1;
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0 || exp_wr.size() != 0) begin
            errors++; $display("FAIL stall_timeout: pending done=%0d wr=%0d, want 0 0", exp_done.size(), exp_wr.size());
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_len_boundary();
        int n;
        set_ch(0, 1'b0, 32'h100, 32'h0, 3'd0);
        req_valid = 2'b01;
        exp_done.push_back('{2'b01, 32'h44332211, 1'b1, cyc + 6});
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0) begin errors++; $display("FAIL len0_timeout: %0d done pending, want 0", exp_done.size()); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_rr();
        int n;
        set_ch(0, 1'b0, 32'h100, 32'h0, 3'd1);
        set_ch(1, 1'b0, 32'h101, 32'h0, 3'd1);
        rr_exp.push_back(2'b01);
        rr_valid = 2'b01;
        n = 0;
        while (rr_exp.size() != 0 && n < 40) begin tick(); n++; end
        rr_valid = 2'b00;
        tick(); tick();
        // Pointer now sits after channel 0, so channel 1 must win first.
        rr_exp.push_back(2'b10); rr_exp.push_back(2'b01); rr_exp.push_back(2'b10);
        rr_exp.push_back(2'b01); rr_exp.push_back(2'b10);
        rr_valid = 2'b11;
        while (rr_exp.size() > 1 && n < 80) begin tick(); n++; end
        rr_valid = 2'b00;
        while (rr_exp.size() != 0 && n < 80) begin tick(); n++; end
        checks++;
        if (rr_exp.size() != 0) begin errors++; $display("FAIL rr_timeout: %0d grants pending, want 0", rr_exp.size()); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int n;
        set_ch(1, 1'b0, 32'h100, 32'h0, 3'd4);
        req_valid = 2'b10;
        tick(); tick(); tick();
        rst_in = 1'b0;
        req_valid = 2'b00;
        #1;
        checks += 4;
        if (mem_a !== 32'h0)     begin errors++; $display("FAIL midrst_mem_a: got %h, want 0", mem_a); end
        if (mem_wr !== 1'b0)     begin errors++; $display("FAIL midrst_mem_wr: got %b, want 0", mem_wr); end
        if (rsp_done !== 2'b00)  begin errors++; $display("FAIL midrst_done: got %b, want 00", rsp_done); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h, want 0", rsp_rdata); end
        tick(); tick();
        rst_in = 1'b1;
        tick();
        set_ch(0, 1'b0, 32'h100, 32'h0, 3'd4);
        req_valid = 2'b01;
        exp_done.push_back('{2'b01, 32'h44332211, 1'b1, cyc + 6});
        tick();
        checks++;
        if (mem_a !== 32'h100) begin errors++; $display("FAIL postrst_addr: got %h, want 00000100", mem_a); end
        n = 0;
        while (exp_done.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (exp_done.size() != 0) begin errors++; $display("FAIL postrst_timeout: %0d done pending, want 0", exp_done.size()); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        mem[512] = 8'hA5; mem[513] = 8'h5C;
        test_reset();
        test_read();
        test_io_write();
        test_fixed_prio();
        test_flush();
        test_rdy_stall();
        test_len_boundary();
        test_rr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
